// File: rtl/sqrt2_host.sv
// Bus-side initiator for one sqrt2 FP16 square-root unit: request/response handshakes on one side, shared IO_DATA bus on the other.
// Optional flag/encoding consistency checker enabled by defining SQRT2_HOST_CHECK_EN.
`timescale 1ns/1ps
module sqrt2_host #(
  parameter int DRIVE_CYCLES = 2,
  parameter int TIMEOUT      = 100,
  parameter int GAP_CYCLES   = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic [15:0] REQ_DATA,
  output logic        RSP_VALID,
  input  logic        RSP_READY,
  output logic [15:0] RSP_DATA,
  output logic [4:0]  RSP_FLAGS,
  inout  wire  [15:0] SQ_DATA,
  output logic        SQ_ENABLE,
  input  logic        SQ_RESULT,
  input  logic        SQ_IS_NAN,
  input  logic        SQ_IS_PINF,
  input  logic        SQ_IS_NINF
);

  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam int DC_W  = $clog2(DRIVE_CYCLES + 1);
  localparam int GC_W  = $clog2(GAP_CYCLES + 1);
  localparam int MX_W  = (TO_W > DC_W) ? TO_W : DC_W;
  localparam int CNT_W = (MX_W > GC_W) ? MX_W : GC_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_WAIT,
    S_RELEASE,
    S_GAP
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_inc;
  logic [15:0]        op_data;
  logic               drv_en;
  logic               chk_err;

  // The counter never passes TIMEOUT, so a long WAIT cannot wrap into a false early timeout.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == CNT_W'(TIMEOUT))
      return v;
    return v + CNT_W'(1);
  endfunction

`ifdef SQRT2_HOST_CHECK_EN
  function automatic logic flags_bad(input logic [15:0] d, input logic ninf,
                                     input logic pinf, input logic nan);
    logic exp_max;
    exp_max = (d[14:10] == 5'h1F);
    return (nan  && (!exp_max || (d[9:0] == 10'h000))) ||
           (pinf && (d != 16'h7C00)) ||
           (ninf && (d != 16'hFC00)) ||
           (!nan && !pinf && !ninf && exp_max);
  endfunction

  assign chk_err = flags_bad(SQ_DATA, SQ_IS_NINF, SQ_IS_PINF, SQ_IS_NAN);
`else
  assign chk_err = 1'b0;
`endif

  assign cnt_inc   = sat_inc(cnt);
  assign REQ_READY = (state == S_IDLE) && !RSP_VALID;
  // Only the DRIVE state owns the bus; sqrt2 drives it at all other times.
  assign SQ_DATA   = drv_en ? op_data : 16'hzzzz;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= S_IDLE;
      cnt       <= '0;
      drv_en    <= 1'b0;
      SQ_ENABLE <= 1'b0;
      RSP_VALID <= 1'b0;
      RSP_DATA  <= '0;
      RSP_FLAGS <= '0;
    end else begin
      if (RSP_VALID && RSP_READY)
        RSP_VALID <= 1'b0;

      case (state)
        S_IDLE: begin
          if (REQ_VALID && REQ_READY) begin
            op_data   <= REQ_DATA;
            cnt       <= CNT_W'(DRIVE_CYCLES - 1);
            drv_en    <= 1'b1;
            SQ_ENABLE <= 1'b1;
            state     <= S_DRIVE;
          end
        end

        S_DRIVE: begin
          if (cnt == '0) begin
            drv_en <= 1'b0;
            state  <= S_WAIT;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        // A result sampled on the edge the counter would hit TIMEOUT takes priority.
        S_WAIT: begin
          if (SQ_RESULT) begin
            RSP_DATA  <= SQ_DATA;
            RSP_FLAGS <= {chk_err, 1'b0, SQ_IS_NINF, SQ_IS_PINF, SQ_IS_NAN};
            RSP_VALID <= 1'b1;
            cnt       <= '0;
            state     <= S_RELEASE;
          end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
            RSP_DATA  <= 16'hFE00;
            RSP_FLAGS <= 5'b01000;
            RSP_VALID <= 1'b1;
            cnt       <= '0;
            state     <= S_RELEASE;
          end else begin
            cnt <= cnt_inc;
          end
        end

        S_RELEASE: begin
          SQ_ENABLE <= 1'b0;
          cnt       <= CNT_W'(GAP_CYCLES - 1);
          state     <= S_GAP;
        end

        S_GAP: begin
          if (cnt == '0)
            state <= S_IDLE;
          else
            cnt <= cnt - CNT_W'(1);
        end

        default: begin
          state     <= S_IDLE;
          drv_en    <= 1'b0;
          SQ_ENABLE <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sqrt2_host.sv
// Directed bench for sqrt2_host with a behavioural sqrt2 stub on a pulled-up shared bus.
`timescale 1ns/1ps
module tb_sqrt2_host;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic [4:0]  rsp_flags;
  tri1  [15:0] sq_data;
  logic        sq_enable;
  logic        sq_result;
  logic        sq_nan;
  logic        sq_pinf;
  logic        sq_ninf;

  logic        stub_drv;
  logic [15:0] stub_val;
  logic [15:0] stub_op;
  int          stub_state;
  int          stub_cnt;
  int          stub_lat;
  logic        stub_respond;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int e0;
  int seen;

  assign sq_data = stub_drv ? stub_val : 16'hzzzz;

  always #5 clk = ~clk;

  sqrt2_host dut (
    .CLK        (clk),
    .RESET      (rst),
    .REQ_VALID  (req_valid),
    .REQ_READY  (req_ready),
    .REQ_DATA   (req_data),
    .RSP_VALID  (rsp_valid),
    .RSP_READY  (rsp_ready),
    .RSP_DATA   (rsp_data),
    .RSP_FLAGS  (rsp_flags),
    .SQ_DATA    (sq_data),
    .SQ_ENABLE  (sq_enable),
    .SQ_RESULT  (sq_result),
    .SQ_IS_NAN  (sq_nan),
    .SQ_IS_PINF (sq_pinf),
    .SQ_IS_NINF (sq_ninf)
  );

  // Stub result table: {data, ninf, pinf, nan}
  function automatic logic [18:0] stub_model(input logic [15:0] op);
    case (op)
      16'h4400: return {16'h4000, 3'b000};
      16'hFC00: return {16'hFE00, 3'b001};
      16'h7C00: return {16'h7C00, 3'b010};
      16'h3C00: return {16'h3C00, 3'b000};
      16'h1234: return {16'h4000, 3'b010};
      default:  return {16'h0000, 3'b000};
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      stub_state <= 0;
      stub_drv   <= 1'b0;
      stub_val   <= 16'h0000;
      sq_result  <= 1'b0;
      sq_nan     <= 1'b0;
      sq_pinf    <= 1'b0;
      sq_ninf    <= 1'b0;
    end else begin
      case (stub_state)
        0: if (sq_enable) begin
          stub_op    <= sq_data;
          stub_cnt   <= stub_lat;
          stub_state <= 1;
        end
        1: begin
          if (!sq_enable) stub_state <= 0;
          else if (stub_cnt != 0) stub_cnt <= stub_cnt - 1;
          else if (stub_respond) begin
            {stub_val, sq_ninf, sq_pinf, sq_nan} <= stub_model(stub_op);
            stub_drv   <= 1'b1;
            sq_result  <= 1'b1;
            stub_state <= 2;
          end
        end
        default: begin
          sq_result <= 1'b0;
          if (!sq_enable) begin
            stub_drv   <= 1'b0;
            sq_nan     <= 1'b0;
            sq_pinf    <= 1'b0;
            sq_ninf    <= 1'b0;
            stub_state <= 0;
          end
        end
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [15:0] d);
    chk("req_ready_before_send", {15'b0, req_ready}, 16'd1);
    req_valid = 1'b1;
    req_data  = d;
    tick();
    req_valid = 1'b0;
    e0 = cyc;
  endtask

  task automatic wait_rsp();
    int n;
    n = 0;
    while (!rsp_valid && n < 300) begin
      tick();
      n++;
    end
  endtask

  task automatic consume_and_idle();
    int n;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    n = 0;
    while (!req_ready && n < 20) begin
      tick();
      n++;
    end
  endtask

  initial begin
    rst          = 1'b1;
    req_valid    = 1'b0;
    req_data     = 16'h0000;
    rsp_ready    = 1'b0;
    stub_respond = 1'b1;
    stub_lat     = 2;
    repeat (3) tick();

    chk("rst_req_ready", {15'b0, req_ready}, 16'd1);
    chk("rst_rsp_valid", {15'b0, rsp_valid}, 16'd0);
    chk("rst_rsp_data",  rsp_data, 16'h0000);
    chk("rst_rsp_flags", {11'b0, rsp_flags}, 16'h0000);
    chk("rst_sq_enable", {15'b0, sq_enable}, 16'd0);
    chk("rst_bus_hiz",   sq_data, 16'hFFFF);
    rst = 1'b0;
    tick();

    // sqrt(4.0) = 2.0, with bus drive window and gap timing
    send(16'h4400);
    chk("drv1_enable", {15'b0, sq_enable}, 16'd1);
    chk("drv1_bus",    sq_data, 16'h4400);
    tick();
    chk("drv2_bus",    sq_data, 16'h4400);
    tick();
    chk("wait_bus_hiz", sq_data, 16'hFFFF);
    chk("wait_enable", {15'b0, sq_enable}, 16'd1);
    wait_rsp();
    chk("t1_latency", 16'(cyc - e0), 16'd5);
    chk("t1_data",    rsp_data, 16'h4000);
    chk("t1_flags",   {11'b0, rsp_flags}, 16'h0000);
    chk("release_enable", {15'b0, sq_enable}, 16'd1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("consume_drop",   {15'b0, rsp_valid}, 16'd0);
    chk("gap1_enable",    {15'b0, sq_enable}, 16'd0);
    chk("gap1_req_ready", {15'b0, req_ready}, 16'd0);
    tick();
    chk("gap2_req_ready", {15'b0, req_ready}, 16'd0);
    tick();
    chk("idle_req_ready", {15'b0, req_ready}, 16'd1);

    // sqrt(-inf) = NaN
    send(16'hFC00);
    wait_rsp();
    chk("ninf_data",  rsp_data, 16'hFE00);
    chk("ninf_flags", {11'b0, rsp_flags}, 16'h0001);
    consume_and_idle();

    // sqrt(+inf) = +inf
    send(16'h7C00);
    wait_rsp();
    chk("pinf_data",  rsp_data, 16'h7C00);
    chk("pinf_flags", {11'b0, rsp_flags}, 16'h0002);
    consume_and_idle();

    // Unit never answers: timeout after DRIVE_CYCLES+TIMEOUT edges
    stub_respond = 1'b0;
    send(16'h4400);
    repeat (101) tick();
    chk("to_not_yet", {15'b0, rsp_valid}, 16'd0);
    tick();
    chk("to_valid", {15'b0, rsp_valid}, 16'd1);
    chk("to_data",  rsp_data, 16'hFE00);
    chk("to_flags", {11'b0, rsp_flags}, 16'h0008);

    // Backpressure: pending request must not be taken while response is held
    req_valid = 1'b1;
    req_data  = 16'h3C00;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_req_ready", {15'b0, req_ready}, 16'd0);
      chk("bp_valid",     {15'b0, rsp_valid}, 16'd1);
      chk("bp_data",      rsp_data, 16'hFE00);
      chk("bp_flags",     {11'b0, rsp_flags}, 16'h0008);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("bp_drop",   {15'b0, rsp_valid}, 16'd0);
    chk("bp_no_acc", {15'b0, sq_enable}, 16'd0);

    // Result on the very edge the counter would time out: result wins
    stub_respond = 1'b1;
    stub_lat     = 99;
    send(16'h7C00);
    wait_rsp();
    chk("edge_latency", 16'(cyc - e0), 16'd102);
    chk("edge_data",    rsp_data, 16'h7C00);
    chk("edge_flags",   {11'b0, rsp_flags}, 16'h0002);
    consume_and_idle();

    // Reset in WAIT aborts the operation without a response
    stub_lat     = 2;
    stub_respond = 1'b0;
    send(16'h4400);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_enable",    {15'b0, sq_enable}, 16'd0);
    chk("abort_bus_hiz",   sq_data, 16'hFFFF);
    chk("abort_rsp_valid", {15'b0, rsp_valid}, 16'd0);
    chk("abort_req_ready", {15'b0, req_ready}, 16'd1);
    seen = 0;
    for (int i = 0; i < 120; i++) begin
      tick();
      if (rsp_valid) seen++;
    end
    chk("abort_no_rsp", 16'(seen), 16'd0);
    stub_respond = 1'b1;
    send(16'h3C00);
    wait_rsp();
    chk("fresh_latency", 16'(cyc - e0), 16'd5);
    chk("fresh_data",    rsp_data, 16'h3C00);
    chk("fresh_flags",   {11'b0, rsp_flags}, 16'h0000);
    consume_and_idle();

    // pinf flag with non-infinity data
    send(16'h1234);
    wait_rsp();
    chk("chk_data", rsp_data, 16'h4000);
`ifdef SQRT2_HOST_CHECK_EN
    chk("chk_flags", {11'b0, rsp_flags}, 16'h0012);
`else
    chk("chk_flags", {11'b0, rsp_flags}, 16'h0002);
`endif
    consume_and_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sqrt2_host.md
# sqrt2_host

Bus-side initiator for the `sqrt2` FP16 square-root unit. It accepts operands on a valid/ready request port and drives them onto the shared bidirectional `IO_DATA` bus under `ENABLE`. It waits for `RESULT`, captures the result word and the special-value flags, and returns them on a valid/ready response port. It sits between the system's FP request fabric and one `sqrt2` instance, and owns all bus-direction control and protocol timing.

## Interface

Parameters:
- `DRIVE_CYCLES`, default 2: number of cycles the operand is driven onto the bus with `SQ_ENABLE` high.
- `TIMEOUT`, default 100: maximum number of WAIT cycles before the operation is abandoned.
- `GAP_CYCLES`, default 2: number of idle cycles with `SQ_ENABLE` low between operations.

Ports (clock and reset first):
- `CLK` input 1: sole clock. Everything is sampled and updated on the rising edge.
- `RESET` input 1: synchronous, active-high reset.
- `REQ_VALID` input 1: request operand is valid.
- `REQ_READY` output 1: host can accept a request.
- `REQ_DATA` input 16: FP16 operand.
- `RSP_VALID` output 1: response is valid.
- `RSP_READY` input 1: consumer accepts the response.
- `RSP_DATA` output 16: FP16 result.
- `RSP_FLAGS` output 5: {check_err, timeout, ninf, pinf, nan}.
- `SQ_DATA` inout 16: connects to `sqrt2` `IO_DATA`.
- `SQ_ENABLE` output 1: connects to `ENABLE`.
- `SQ_RESULT` input 1: connects to `RESULT`.
- `SQ_IS_NAN` input 1: connects to `IS_NAN`.
- `SQ_IS_PINF` input 1: connects to `IS_PINF`.
- `SQ_IS_NINF` input 1: connects to `IS_NINF`.

## Operation

- FSM states: IDLE, DRIVE, WAIT, RELEASE, GAP.
- **IDLE**
  - `REQ_READY = !RSP_VALID`.
  - On the edge where `REQ_VALID & REQ_READY`: latch `REQ_DATA` into the operand register, load the counter with `DRIVE_CYCLES-1`, go to DRIVE.
- **DRIVE**
  - `SQ_ENABLE=1`; `SQ_DATA` is driven with the operand register.
  - `SQ_RESULT` is ignored.
  - When the counter reaches 0: clear the counter, go to WAIT.
- **WAIT**
  - `SQ_ENABLE=1`; `SQ_DATA` is high-Z.
  - Each edge with `SQ_RESULT=1`: capture `SQ_DATA` into `RSP_DATA` and `{0,0,SQ_IS_NINF,SQ_IS_PINF,SQ_IS_NAN}` into `RSP_FLAGS`, set `RSP_VALID`, go to RELEASE.
  - Otherwise increment the counter. When the counter reaches `TIMEOUT`: set `RSP_DATA=16'hFE00`, set `RSP_FLAGS` to timeout=1 with all other bits 0, set `RSP_VALID`, go to RELEASE.
  - Counter width is `$clog2(TIMEOUT+1)`. The counter saturates and never wraps.
- **RELEASE**
  - `SQ_ENABLE=1` for exactly one cycle, bus still high-Z.
  - Load `GAP_CYCLES-1`, go to GAP.
- **GAP**
  - `SQ_ENABLE=0` for `GAP_CYCLES` cycles, then go to IDLE.
- **Response register**
  - Single entry. `RSP_VALID` clears on the edge where `RSP_VALID & RSP_READY`.
  - `RSP_DATA` and `RSP_FLAGS` are stable while `RSP_VALID=1`.
- No new request is accepted while a response is unconsumed; there is no overflow path.
- `SQ_DATA` is driven only in DRIVE, so there is no bus contention with `sqrt2`.

## Timing

- Reset values: `REQ_READY=1` (follows IDLE with `RSP_VALID=0`), `RSP_VALID=0`, `RSP_DATA=0`, `RSP_FLAGS=0`, `SQ_ENABLE=0`, `SQ_DATA` high-Z. State is IDLE and all counters are 0.
- Request accepted at edge E0:
  - DRIVE occupies cycles E0+1 through E0+`DRIVE_CYCLES`.
  - If `SQ_RESULT` is first sampled high at the k-th WAIT edge (k ≥ 1), `RSP_VALID` is high after edge E0+`DRIVE_CYCLES`+k.
  - On timeout, `RSP_VALID` is high after edge E0+`DRIVE_CYCLES`+`TIMEOUT`.
- Next-request spacing: after `RSP_VALID` rises, at least 1+`GAP_CYCLES` cycles pass before IDLE. `REQ_READY` additionally requires the response to be consumed.
- `SQ_RESULT` asserted in the same WAIT cycle the counter hits `TIMEOUT`: the result wins, and the timeout bit is 0.
- Reset asserted mid-operation, in any state: at the next edge go to IDLE, set `SQ_ENABLE=0`, release the bus, and clear `RSP_VALID`. No response is emitted for the aborted operation.

## Configuration

- Macro `SQRT2_HOST_CHECK_EN`.
  - **Defined:** on capture, `RSP_FLAGS[4]` (check_err) is set when the flags disagree with the data encoding:
    - `nan=1` but the exponent is not 5'h1F, or the mantissa is 0;
    - `pinf=1` but the data is not 16'h7C00;
    - `ninf=1` but the data is not 16'hFC00;
    - all flags 0 but the exponent is 5'h1F.
  - **Not defined:** `RSP_FLAGS[4]` is tied to 0 and no checker logic exists.

## Test plan

Each scenario uses a `sqrt2` instance, or a stub for the timeout case.

- Request 16'h4400 → `RSP_DATA=16'h4000`, `RSP_FLAGS=5'b00000`. `SQ_DATA` is driven for exactly 2 cycles, then high-Z.
- Request 16'hFC00 → `RSP_DATA=16'hFE00`, nan=1. Request 16'h7C00 → `RSP_DATA=16'h7C00`, pinf=1.
- Stub never asserts `SQ_RESULT` → `RSP_VALID` rises 102 cycles after accept, with `RSP_DATA=16'hFE00` and `RSP_FLAGS=5'b01000`.
- Hold `RSP_READY=0` for 10 cycles after a response → `REQ_READY` stays 0, and `RSP_DATA`/`RSP_FLAGS` stay stable. On acceptance, `RSP_VALID` drops on that edge.
- Assert `RESET` during WAIT → next cycle `SQ_ENABLE=0` and `SQ_DATA` is high-Z. No response appears, and a fresh request for 16'h3C00 then returns 16'h3C00.
- With `SQRT2_HOST_CHECK_EN` defined, a stub returns data 16'h4000 with `IS_PINF=1` → `RSP_FLAGS[4]=1`.
